// File: rtl/seq_bin2bcd.sv
// Iterative double-dabble binary-to-BCD converter, one operand bit per clock; BCD_SIGNED_EN selects two's complement input.
// Latency: operand accepted at edge N gives out_valid after edge N+WIDTH; one result per WIDTH+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready is low while busy or holding a result.
module seq_bin2bcd #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      binary,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  sign,
    output logic                  overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    opnd_q, opnd_shf, magnitude;
    logic [4*DIGITS-1:0] digits_q, digits_adj, digits_shf;
    logic [CW-1:0]       cnt_q;
    logic                ovf_q, ovf_nxt, last_shift;
    logic                overflow_q;
    logic [4*DIGITS-1:0] bcd_q;

`ifdef BCD_SIGNED_EN
    logic neg, sgn_q, sign_q;
    assign neg       = binary[WIDTH-1];
    // Magnitude is taken as WIDTH-bit unsigned, so the most negative value maps to 2^(WIDTH-1).
    assign magnitude = neg ? (~binary + {{(WIDTH-1){1'b0}}, 1'b1}) : binary;
    assign sign      = sign_q;
`else
    assign magnitude = binary;
    assign sign      = 1'b0;
`endif

    always_comb begin
        digits_adj = digits_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (digits_q[4*k +: 4] >= 4'd5)
                digits_adj[4*k +: 4] = digits_q[4*k +: 4] + 4'd3;
        end
    end

    // The top digit's bit 3 falls off the end on the shift, which is the only way to lose value.
    assign ovf_nxt    = ovf_q | digits_adj[4*DIGITS-1];
    assign digits_shf = {digits_adj[4*DIGITS-2:0], opnd_q[WIDTH-1]};
    assign opnd_shf   = {opnd_q[WIDTH-2:0], 1'b0};
    assign last_shift = (cnt_q == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = SHIFT;
            SHIFT:   if (last_shift) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opnd_q     <= '0;
            digits_q   <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
`ifdef BCD_SIGNED_EN
            sgn_q      <= 1'b0;
            sign_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        opnd_q   <= magnitude;
                        digits_q <= '0;
                        ovf_q    <= 1'b0;
                        cnt_q    <= CW'(WIDTH);
`ifdef BCD_SIGNED_EN
                        sgn_q    <= neg;
`endif
                    end
                end
                SHIFT: begin
                    opnd_q   <= opnd_shf;
                    digits_q <= digits_shf;
                    ovf_q    <= ovf_nxt;
                    cnt_q    <= cnt_q - 1'b1;
                    if (last_shift) begin
                        bcd_q      <= digits_shf;
                        overflow_q <= ovf_nxt;
`ifdef BCD_SIGNED_EN
                        sign_q     <= sgn_q;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bcd      = bcd_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Directed bench: a 5-digit and a 4-digit converter driven in lockstep with hand-computed results.
module tb_seq_bin2bcd;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] binary;
    logic        out_ready;
    logic        in_ready, out_valid, sign, overflow;
    logic [19:0] bcd;
    logic        in_ready4, out_valid4, sign4, overflow4;
    logic [15:0] bcd4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_bin2bcd #(.WIDTH(16), .DIGITS(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .binary(binary),
        .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd), .sign(sign), .overflow(overflow)
    );

    seq_bin2bcd #(.WIDTH(16), .DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .binary(binary),
        .out_valid(out_valid4), .out_ready(out_ready), .bcd(bcd4), .sign(sign4), .overflow(overflow4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one operand, waits (bounded) for the result and checks latency and both converters.
    task automatic convert(input logic [15:0] val, input logic [19:0] e5, input logic e_sign,
                           input logic e_ovf5, input logic [15:0] e4, input logic e_ovf4,
                           input string tag);
        int cyc;
        @(negedge clk);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        binary   = val;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 64) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, cyc, 32'd16);
        check({tag, "_bcd"}, {12'd0, bcd}, {12'd0, e5});
        check({tag, "_sign"}, {31'd0, sign}, {31'd0, e_sign});
        check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, e_ovf5});
        check({tag, "_vld4"}, {31'd0, out_valid4}, 32'd1);
        check({tag, "_bcd4"}, {16'd0, bcd4}, {16'd0, e4});
        check({tag, "_ovf4"}, {31'd0, overflow4}, {31'd0, e_ovf4});
        check({tag, "_sign4"}, {31'd0, sign4}, {31'd0, e_sign});
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_idle_rdy"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_idle_vld"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        binary    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_bcd", {12'd0, bcd}, 32'd0);
        check("rst_sign", {31'd0, sign}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

`ifdef BCD_SIGNED_EN
        convert(16'hFFFF, 20'h00001, 1'b1, 1'b0, 16'h0001, 1'b0, "ffff");
        release_out("ffff");
        convert(16'h8000, 20'h32768, 1'b1, 1'b0, 16'h2768, 1'b1, "min");
        release_out("min");
        convert(16'h7FFF, 20'h32767, 1'b0, 1'b0, 16'h2767, 1'b1, "max");
        release_out("max");
`else
        convert(16'hFFFF, 20'h65535, 1'b0, 1'b0, 16'h5535, 1'b1, "ffff");
        release_out("ffff");
`endif
        convert(16'd0, 20'h00000, 1'b0, 1'b0, 16'h0000, 1'b0, "zero");
        release_out("zero");
        convert(16'd9999, 20'h09999, 1'b0, 1'b0, 16'h9999, 1'b0, "d9999");
        release_out("d9999");
        convert(16'd10000, 20'h10000, 1'b0, 1'b0, 16'h0000, 1'b1, "d10000");
        release_out("d10000");

        // Backpressure: result held, new operand ignored while DONE.
        convert(16'd4321, 20'h04321, 1'b0, 1'b0, 16'h4321, 1'b0, "bp");
        @(negedge clk);
        binary   = 16'd7;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_vld", {31'd0, out_valid}, 32'd1);
            check("bp_hold_bcd", {12'd0, bcd}, {12'd0, 20'h04321});
            check("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("bp_rel_vld", {31'd0, out_valid}, 32'd0);
        check("bp_rel_rdy", {31'd0, in_ready}, 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check("bp_ignored_vld", {31'd0, out_valid}, 32'd0);
        check("bp_idle_bcd", {12'd0, bcd}, {12'd0, 20'h04321});

        // Reset in the middle of a conversion.
        @(negedge clk);
        binary   = 16'd5678;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_vld", {31'd0, out_valid}, 32'd0);
        check("mid_rst_bcd", {12'd0, bcd}, 32'd0);
        check("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        convert(16'd1234, 20'h01234, 1'b0, 1'b0, 16'h1234, 1'b0, "d1234");
        release_out("d1234");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
